// File: rtl/m_inport_fifo.sv
// m_inport_fifo
//   Picoblaze input-port peripheral. Buffers bytes from an external producer
//   in a small FIFO. It presents the FIFO head (data register at BASE) and a
//   status byte (at BASE+1) on a registered in_port. An INPUT from the data
//   register pops the FIFO. A non-empty FIFO raises irq.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous reset, active low
//     port_id      Picoblaze port address
//     read_strobe  Picoblaze INPUT strobe (one cycle)
//     in_port      registered read data; 8'h00 when not addressed
//     in_data      producer data
//     in_valid     producer offers in_data this cycle
//     in_ready     FIFO not full (combinational)
//     irq          FIFO not empty (registered)
//
//   Status byte: {LVL[3:0], UNF, OVF, full, empty}. LVL is the count saturated
//   at 15. OVF and UNF are sticky. A status INPUT clears both flags, unless a
//   new event occurs in the same cycle.
module m_inport_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  BASE       = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       port_id,
    input  logic             read_strobe,
    output logic [7:0]       in_port,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             irq
);

    localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0]           STAT_ID  = BASE + 8'd1;
    localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [7:0]            in_port_q, in_port_d;
    logic                  irq_q, irq_d;

    logic       full, empty;
    logic       sel_data, sel_stat;
    logic       push, pop;
    logic [7:0] count_ext, head_ext;
    logic [3:0] lvl;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign sel_data = (port_id == BASE);
    assign sel_stat = (port_id == STAT_ID);
    assign push     = in_valid & ~full;
    assign pop      = read_strobe & sel_data & ~empty;

    assign count_ext = 8'(count_q);
    assign head_ext  = 8'(mem_q[rd_ptr_q]);
    assign lvl       = (count_ext > 8'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;

        // A fresh event in the same cycle as a status read keeps the flag set.
        ovf_d = (in_valid & full) | (ovf_q & ~(read_strobe & sel_stat));
        unf_d = (read_strobe & sel_data & empty) | (unf_q & ~(read_strobe & sel_stat));

        irq_d = (count_d != '0);

        // Read data and status come from the state before this cycle's update.
        in_port_d = 8'h00;
        if (sel_data)      in_port_d = empty ? 8'h00 : head_ext;
        else if (sel_stat) in_port_d = {lvl, unf_q, ovf_q, full, empty};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            in_port_q <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            in_port_q <= in_port_d;
            irq_q     <= irq_d;
        end
    end

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_port  = in_port_q;
    assign in_ready = ~full;
    assign irq      = irq_q;

endmodule
